// File: rtl/pulse_reporter.sv
// -----------------------------------------------------------------------------
// pulse_reporter
//
// Measures each high pulse on pulse_in in baud ticks and reports the length
// to a host as an 8N1 UART frame: HEADER, count[15:8], count[7:0], LSB first.
//
// Optional build macro:
//    CHECKSUM_EN  - appends a fourth byte equal to the XOR of bytes 0..2.
//
// Ports:
//    sysclk      in   system clock, all logic on its rising edge
//    rst_n       in   asynchronous active-low reset
//    tick        in   baud strobe, one sysclk cycle wide per bit period
//    pulse_in    in   pulse to measure, asynchronous to sysclk
//    clr_ovr     in   synchronous, level-sensitive clear of overrun
//    txd         out  UART serial output, idles high
//    busy        out  high from report capture until the final stop bit ends
//    overrun     out  sticky, set when a report is dropped while busy
//    last_count  out  most recently captured pulse length
// -----------------------------------------------------------------------------
module pulse_reporter #(
   parameter int unsigned CNT_W       = 9,
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             pulse_in,
   input  logic             clr_ovr,
   output logic             txd,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] last_count
);

`ifdef CHECKSUM_EN
   localparam logic [1:0] LAST_BYTE = 2'd3;
`else
   localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      DATA,
      STOP
   } state_e;

   // ---------------------------------------------------------------------------
   // Input synchroniser and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ps;
   logic                   ps_prev_q;
   logic                   rise;
   logic                   fall;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         ps_prev_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
         ps_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ps   = sync_q[SYNC_STAGES-1];
   assign rise = ps & ~ps_prev_q;
   assign fall = ~ps & ps_prev_q;

   // ---------------------------------------------------------------------------
   // Pulse-length counter and capture
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] last_count_q, last_count_d;
   logic             overrun_q, overrun_d;
   logic             accept;

   state_e           state_q;
   logic             txd_q;
   logic             busy_q;
   logic [CNT_W-1:0] data_q;
   logic [7:0]       byte_q;
   logic [2:0]       bit_idx_q;
   logic [1:0]       byte_idx_q;

   // Ticks are counted whenever the previous cycle saw ps high; this makes a
   // tick coincident with the falling edge part of the capture while a tick
   // coincident with the rising edge is lost to the clear.
   assign cnt_inc = (tick && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
   assign accept  = fall && (state_q == IDLE);

   always_comb begin
      cnt_d        = cnt_q;
      last_count_d = last_count_q;
      overrun_d    = overrun_q;
      if (rise) begin
         cnt_d = '0;
      end else if (ps_prev_q) begin
         cnt_d = cnt_inc;
      end
      if (fall) begin
         last_count_d = cnt_inc;
      end
      // A new overrun takes priority over a simultaneous clear.
      if (fall && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (clr_ovr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         last_count_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         last_count_q <= last_count_d;
         overrun_q    <= overrun_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame byte selection
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] frame_byte(input logic [1:0]       idx,
                                             input logic [CNT_W-1:0] val);
      logic [15:0] ext;
      logic [7:0]  res;
      ext = 16'(val);
      case (idx)
         2'd0:    res = HEADER;
         2'd1:    res = ext[15:8];
         2'd2:    res = ext[7:0];
`ifdef CHECKSUM_EN
         default: res = HEADER ^ ext[15:8] ^ ext[7:0];
`else
         default: res = 8'h00;
`endif
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // UART transmit FSM; txd and busy are registered and only move after a tick
   // ---------------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         data_q     <= '0;
         byte_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  data_q     <= cnt_inc;
                  busy_q     <= 1'b1;
                  byte_idx_q <= '0;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (tick) begin
                  byte_q  <= frame_byte(2'd0, data_q);
                  txd_q   <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (tick) begin
                  txd_q     <= byte_q[0];
                  byte_q    <= byte_q >> 1;
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     txd_q     <= byte_q[0];
                     byte_q    <= byte_q >> 1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (byte_idx_q == LAST_BYTE) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     // Next start bit begins straight out of this stop bit.
                     byte_idx_q <= byte_idx_q + 2'd1;
                     byte_q     <= frame_byte(byte_idx_q + 2'd1, data_q);
                     txd_q      <= 1'b0;
                     state_q    <= START;
                  end
               end
            end
            default: begin
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign txd        = txd_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign last_count = last_count_q;

endmodule

// File: tb/tb_pulse_reporter.sv
// -----------------------------------------------------------------------------
// tb_pulse_reporter
//
// Directed, table-driven bench for pulse_reporter (CNT_W=9, HEADER=A5,
// SYNC_STAGES=2). Honours the CHECKSUM_EN macro when computing expected frames.
// A tick is generated every TP sysclk cycles.
// -----------------------------------------------------------------------------
module tb_pulse_reporter;

   localparam int unsigned TP = 8;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       pulse_in = 1'b0;
   logic       clr_ovr = 1'b0;
   logic       txd;
   logic       busy;
   logic       overrun;
   logic [8:0] last_count;

   int checks = 0;
   int failures = 0;

   pulse_reporter #(
      .CNT_W      (9),
      .HEADER     (8'hA5),
      .SYNC_STAGES(2)
   ) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .tick      (tick),
      .pulse_in  (pulse_in),
      .clr_ovr   (clr_ovr),
      .txd       (txd),
      .busy      (busy),
      .overrun   (overrun),
      .last_count(last_count)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      int unsigned ph;
      ph = 0;
      forever begin
         @(posedge sysclk);
         #1;
         ph   = (ph + 1) % TP;
         tick = (ph == 0);
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      do @(negedge sysclk); while (tick !== 1'b1);
   endtask

   // Pulse starts 2 cycles after a tick and lasts an exact multiple of the tick
   // period, so it covers exactly nticks tick strobes. nticks=0 gives a
   // 3-cycle pulse that sees no tick at all.
   task automatic do_pulse(input int unsigned nticks);
      wait_tick();
      repeat (2) @(negedge sysclk);
      pulse_in = 1'b1;
      if (nticks == 0) repeat (3) @(negedge sysclk);
      else repeat (nticks * TP) @(negedge sysclk);
      pulse_in = 1'b0;
   endtask

   task automatic rx_byte(output logic [7:0] b, output logic ok);
      int unsigned n;
      b  = 'x;
      ok = 1'b0;
      n  = 0;
      while (txd !== 1'b0 && n < 400) begin
         @(negedge sysclk);
         n++;
      end
      if (n >= 400) return;
      repeat (TP / 2) @(negedge sysclk);
      if (txd !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         repeat (TP) @(negedge sysclk);
         b[i] = txd;
      end
      repeat (TP) @(negedge sysclk);
      ok = (txd === 1'b1);
   endtask

   task automatic rx_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] exp_b [4];
      logic [7:0] got;
      logic       ok;
      int unsigned nb;
      exp_b[0] = 8'hA5;
      exp_b[1] = b1;
      exp_b[2] = b2;
      exp_b[3] = 8'hA5 ^ b1 ^ b2;
`ifdef CHECKSUM_EN
      nb = 4;
`else
      nb = 3;
`endif
      for (int i = 0; i < int'(nb); i++) begin
         rx_byte(got, ok);
         check($sformatf("%s byte%0d framing", tag, i), 32'(ok), 32'd1);
         check($sformatf("%s byte%0d value", tag, i), 32'(got), 32'(exp_b[i]));
      end
      // Sampled mid final stop bit: still busy; one tick later: idle.
      check($sformatf("%s busy in last stop", tag), 32'(busy), 32'd1);
      repeat (TP) @(negedge sysclk);
      check($sformatf("%s busy after frame", tag), 32'(busy), 32'd0);
      check($sformatf("%s txd idle after frame", tag), 32'(txd), 32'd1);
   endtask

   task automatic expect_quiet(input string tag, input int unsigned nticks);
      logic bad;
      bad = 1'b0;
      repeat (nticks * TP) begin
         @(negedge sysclk);
         if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   typedef struct {
      int unsigned ticks;
      int unsigned exp_cnt;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{ticks: 131, exp_cnt: 131, b1: 8'h00, b2: 8'h83};
      vecs[1] = '{ticks: 392, exp_cnt: 392, b1: 8'h01, b2: 8'h88};
      vecs[2] = '{ticks: 600, exp_cnt: 511, b1: 8'h01, b2: 8'hFF};
      vecs[3] = '{ticks: 0,   exp_cnt: 0,   b1: 8'h00, b2: 8'h00};
      vecs[4] = '{ticks: 1,   exp_cnt: 1,   b1: 8'h00, b2: 8'h01};
      vecs[5] = '{ticks: 256, exp_cnt: 256, b1: 8'h01, b2: 8'h00};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge sysclk);
      check("reset txd", 32'(txd), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset last_count", 32'(last_count), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge sysclk);

      // Table-driven single pulses
      foreach (vecs[k]) begin
         do_pulse(vecs[k].ticks);
         repeat (4) @(negedge sysclk);
         check($sformatf("vec%0d last_count", k), 32'(last_count), 32'(vecs[k].exp_cnt));
         rx_frame($sformatf("vec%0d", k), vecs[k].b1, vecs[k].b2);
      end
      check("no overrun after table", 32'(overrun), 32'd0);

      // Second pulse ends while the first frame is in byte 1
      do_pulse(10);
      repeat (4) @(negedge sysclk);
      check("ovr first last_count", 32'(last_count), 32'd10);
      fork
         rx_frame("ovr first", 8'h00, 8'h0A);
         begin
            repeat (8) wait_tick();
            do_pulse(5);
         end
      join
      check("ovr overrun set", 32'(overrun), 32'd1);
      check("ovr last_count", 32'(last_count), 32'd5);
      expect_quiet("ovr no second frame", 40);
      check("ovr still sticky", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      @(negedge sysclk);
      clr_ovr = 1'b0;
      @(negedge sysclk);
      check("ovr cleared", 32'(overrun), 32'd0);

      // Reset in the middle of byte 1 data bits (count 7 -> byte 1 all zeros)
      do_pulse(7);
      begin
         int unsigned n;
         n = 0;
         while (txd !== 1'b0 && n < 400) begin
            @(negedge sysclk);
            n++;
         end
         check("rst frame started", 32'(n < 400), 32'd1);
      end
      repeat (13 * TP) @(negedge sysclk);
      check("rst pre txd low", 32'(txd), 32'd0);
      check("rst pre busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst async txd", 32'(txd), 32'd1);
      check("rst async busy", 32'(busy), 32'd0);
      check("rst async last_count", 32'(last_count), 32'd0);
      @(negedge sysclk);
      rst_n = 1'b1;
      expect_quiet("rst no resend", 40);
      do_pulse(20);
      repeat (4) @(negedge sysclk);
      check("rst after last_count", 32'(last_count), 32'd20);
      rx_frame("rst after", 8'h00, 8'h14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_reporter.md
Name: pulse_reporter

Overview:
Downstream consumer of the switch-programmed pulse generator's `out` line.
- Measures each high pulse in baud ticks and captures the length.
- Serialises the length as a 3-byte (optionally 4-byte) 8N1 UART frame on `txd`, paced by the same baud strobe as the generator.
- Gives the host PC a readback of every programmed hold time.

Parameters:
- CNT_W, 9: width of the pulse-length counter; legal range 1..16.
- HEADER, 8'hA5: first byte of every frame.
- SYNC_STAGES, 2: flip-flop stages synchronising `pulse_in` to `sysclk`; minimum 2.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  baud strobe, one sysclk cycle wide per baud period (divider 5207 at 50 MHz).
- pulse_in  in  1  pulse from the generator, asynchronous to sysclk.
- clr_ovr  in  1  synchronous clear of `overrun`; level-sensitive.
- txd  out  1  UART serial output, idles high.
- busy  out  1  high from report capture until the final stop bit ends.
- overrun  out  1  sticky; set when a report is lost.
- last_count  out  CNT_W  most recently captured pulse length.

Behaviour:
Reset (async, rst_n=0):
- txd=1, busy=0, overrun=0, last_count=0.
- Counter, synchroniser and FSM cleared; FSM=IDLE.
- Reset mid-frame aborts the frame immediately (txd=1 on the same assertion); no partial resend after release.

Measurement (all on synchronised `ps`):
- Rising edge of `ps`: counter cleared to 0.
- While `ps`=1, each tick increments the counter.
- Counter saturates at 2^CNT_W-1 and does not wrap.
- Falling edge of `ps`: counter value is copied to last_count and a report request is raised in the same cycle.
- A pulse shorter than one tick reports 0.
- Rise and tick in the same cycle: the clear wins and the count is 0.
- Fall and tick in the same cycle: the tick is counted before capture.

Report handling:
- Request while FSM=IDLE: the value is latched into the frame shift source and busy=1 on the next cycle.
- Request while busy=1: report is discarded, overrun<=1, and last_count still updates.
- clr_ovr and a new overrun in the same cycle: set wins.

Frame format:
- Byte 0: HEADER.
- Byte 1: count[15:8], zero-extended.
- Byte 2: count[7:0].
- Each byte is 8N1, LSB first.

TX FSM (states IDLE, WAIT, START, DATA, STOP):
- IDLE -> WAIT on accepted request.
- WAIT -> START on next tick; txd=0.
- START -> DATA on tick; bit index=0, txd=byte[0].
- DATA: each tick advances the bit index. After bit 7's tick, -> STOP with txd=1.
- STOP on tick: if more bytes remain, -> START (txd=0) with the next byte; otherwise -> IDLE, busy=0.
- Every bit cell is exactly one tick period; bytes are back-to-back with no idle gap.
- txd is registered and changes only in the cycle after a tick.
- Frame length is 30 tick periods (40 with CHECKSUM_EN).
- Latency from pulse fall to txd low is the synchroniser delay + 1 cycle + wait for next tick.

Optional Feature:
CHECKSUM_EN
- Defined: a fourth byte is appended, equal to the XOR of bytes 0..2. Frame is 40 ticks and busy is held for it.
- Undefined: 3-byte frame; no checksum logic is synthesised.

Test Plan:
1. Reset, then pulse_in high for exactly 131 ticks.
   - last_count=131.
   - txd frames A5, 00, 83; busy high for 30 ticks, then 0.
2. Pulse of 392 ticks (all four switches).
   - Bytes A5 01 88.
   - With CHECKSUM_EN, a fourth byte 2C.
3. Pulse of 600 ticks at CNT_W=9.
   - Count saturates, last_count=511.
   - Bytes A5 01 FF.
4. Pulse of 10 ticks, then a second pulse of 5 ticks ending during byte 1 of the first frame.
   - First frame completes unchanged (A5 00 0A).
   - overrun=1, last_count=5, no second frame.
   - clr_ovr pulse returns overrun to 0.
5. Pulse high for less than one tick period (no tick while high).
   - Frame A5 00 00.
6. Assert rst_n=0 mid-DATA of byte 1.
   - txd=1 and busy=0 immediately.
   - After release, the next 20-tick pulse produces a clean frame A5 00 14.
